// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing one-outstanding IMem requests into a 2-entry fetch FIFO feeding IF/ID.
// Optional FETCH_PERF_EN adds saturating drop/bubble counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        StallIn,
  input  logic        RedirectIn,
  input  logic [31:0] RedirectAddrIn,
  output logic        ImemReqOut,
  output logic [31:0] ImemAddrOut,
  input  logic        ImemAckIn,
  input  logic [31:0] ImemDataIn,
  output logic [31:0] InsOut,
  output logic [31:0] AddrOut,
  output logic        ValidOut
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] PerfDropOut,
  output logic [15:0] PerfBubbleOut
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, drop_addr_q, drop_addr_d;
  logic [1:0] count_q, count_d, next_count, wr_idx;
  logic [1:0][31:0] fa_q, fa_d, fi_q, fi_d;
  logic push, pop;
  assign pop        = ValidOut & ~StallIn & ~RedirectIn;
  assign push       = (state_q == REQ) & ImemAckIn & ~RedirectIn;
  assign next_count = count_q + {1'b0, push} - {1'b0, pop};
  assign wr_idx     = count_q - {1'b0, pop};
  always_ff @(posedge clkIn or negedge resetIn)
    if (!resetIn) state_q <= IDLE;
    else          state_q <= state_d;
  // A redirect with a request still in flight must wait out its ack in DROP.
  always_comb begin
    state_d = state_q;
    if (RedirectIn)              state_d = (state_q != IDLE && !ImemAckIn) ? DROP : IDLE;
    else if (state_q == IDLE)    state_d = (next_count < 2'd2) ? REQ : IDLE;
    else if (state_q == REQ)     state_d = (ImemAckIn && next_count == 2'd2) ? IDLE : REQ;
    else                         state_d = ImemAckIn ? IDLE : DROP;
  end
  always_comb begin
    ImemReqOut  = state_q != IDLE;
    ImemAddrOut = (state_q == DROP) ? drop_addr_q : pc_q;
    ValidOut    = count_q != 2'd0;
    InsOut      = ValidOut ? fi_q[0] : NOP_INS;
    AddrOut     = ValidOut ? fa_q[0] : 32'd0;
  end
  always_comb begin
    pc_d        = RedirectIn ? (RedirectAddrIn & ~32'd3) : push ? pc_q + 32'd4 : pc_q;
    drop_addr_d = (RedirectIn && state_q == REQ && !ImemAckIn) ? pc_q : drop_addr_q;
    count_d     = RedirectIn ? 2'd0 : next_count;
    fa_d[0]     = (push && wr_idx == 2'd0) ? pc_q : pop ? fa_q[1] : fa_q[0];
    fi_d[0]     = (push && wr_idx == 2'd0) ? ImemDataIn : pop ? fi_q[1] : fi_q[0];
    fa_d[1]     = (push && wr_idx == 2'd1) ? pc_q : fa_q[1];
    fi_d[1]     = (push && wr_idx == 2'd1) ? ImemDataIn : fi_q[1];
  end
  always_ff @(posedge clkIn or negedge resetIn)
    if (!resetIn) begin
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= 2'd0;
      fa_q        <= '0;
      fi_q        <= '0;
    end else begin
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      fa_q        <= fa_d;
      fi_q        <= fi_d;
    end
`ifdef FETCH_PERF_EN
  logic [15:0] drop_q, drop_d, bubble_q, bubble_d;
  logic drop_ev, bubble_ev;
  assign drop_ev   = ImemAckIn & ((state_q == DROP) | ((state_q == REQ) & RedirectIn));
  assign bubble_ev = ~ValidOut & ~StallIn;
  always_comb begin
    drop_d        = drop_q + {15'd0, drop_ev && drop_q != 16'hFFFF};
    bubble_d      = bubble_q + {15'd0, bubble_ev && bubble_q != 16'hFFFF};
    PerfDropOut   = drop_q;
    PerfBubbleOut = bubble_q;
  end
  always_ff @(posedge clkIn or negedge resetIn)
    if (!resetIn) begin
      drop_q   <= 16'd0;
      bubble_q <= 16'd0;
    end else begin
      drop_q   <= drop_d;
      bubble_q <= bubble_d;
    end
`endif
endmodule
